// File: rtl/color_pkg.sv
// Shared types and encodings for the color sensor scan sequencer.
package color_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    COUNT    = 2'd2,
    CLASSIFY = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2
  } channel_t;

  // {s2,s3} filter select codes
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  // Published color codes
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] RED   = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;
  localparam logic [1:0] BLUE  = 2'd3;

  function automatic logic [1:0] filter_code(input channel_t ch);
    logic [1:0] code;
    case (ch)
      CH_GREEN: code = FILT_GREEN;
      CH_BLUE:  code = FILT_BLUE;
      default:  code = FILT_RED;
    endcase
    return code;
  endfunction

  function automatic channel_t next_channel(input channel_t ch);
    channel_t nxt;
    case (ch)
      CH_RED:   nxt = CH_GREEN;
      CH_GREEN: nxt = CH_BLUE;
      default:  nxt = CH_RED;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/color_scan_ctrl_freq_edge_counter.sv
// Synchronizes the sensor frequency output and counts its rising edges
// into a saturating counter; count_c is the value the counter takes next.
module freq_edge_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freq,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count_c
);

  logic             meta;
  logic             sync;
  logic             sync_d;
  logic             rise_c;
  logic [CNT_W-1:0] cnt;

  assign rise_c = sync & ~sync_d;

  // Saturating increment, includes an edge seen in the current cycle
  always_comb begin
    count_c = cnt;
    if (en && rise_c && (cnt != '1)) begin
      count_c = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      cnt    <= '0;
    end else begin
      meta   <= freq;
      sync   <= meta;
      sync_d <= sync;
      cnt    <= clr ? '0 : count_c;
    end
  end

endmodule

// File: rtl/color_scan_ctrl.sv
// Scheduled red/green/blue measurement of a TCS3200-style sensor with
// per-channel settle and count windows, publishing counts and dominant color.
module color_scan_ctrl
  import color_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 200000,
  parameter int unsigned SETTLE_CYCLES = 5000,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned MIN_COUNT     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freq,
  input  logic             start,
  input  logic             cont,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [1:0]       color
);

  localparam int unsigned PHASE_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] WINDOW_LAST = PHASE_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   MIN_C       = CNT_W'(MIN_COUNT);

  state_t             state, state_n;
  channel_t           ch, ch_n;
  logic [PHASE_W-1:0] phase, phase_n;
  logic               clr_c;
  logic               en_c;
  logic               store_c;
  logic               publish_c;
  logic [CNT_W-1:0]   count_c;
  logic [CNT_W-1:0]   hold_r, hold_g, hold_b;
  logic [CNT_W-1:0]   max_c;
  logic [1:0]         winner_c;
  logic [1:0]         color_c;

  freq_edge_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .freq    (freq),
    .clr     (clr_c),
    .en      (en_c),
    .count_c (count_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= CH_RED;
      phase <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      phase <= phase_n;
    end
  end

  // Next state; one phase counter is shared by the settle and count windows
  always_comb begin
    state_n   = state;
    ch_n      = ch;
    phase_n   = phase + PHASE_W'(1);
    clr_c     = 1'b0;
    en_c      = 1'b0;
    store_c   = 1'b0;
    publish_c = 1'b0;
    case (state)
      IDLE: begin
        ch_n    = CH_RED;
        phase_n = '0;
        if (start) begin
          state_n = SETTLE;
          clr_c   = 1'b1;
        end
      end
      SETTLE: begin
        if (phase == SETTLE_LAST) begin
          state_n = COUNT;
          phase_n = '0;
        end
      end
      COUNT: begin
        en_c = 1'b1;
        if (phase == WINDOW_LAST) begin
          store_c = 1'b1;
          phase_n = '0;
          clr_c   = 1'b1;
          if (ch == CH_BLUE) begin
            state_n = CLASSIFY;
          end else begin
            state_n = SETTLE;
            ch_n    = next_channel(ch);
          end
        end
      end
      CLASSIFY: begin
        publish_c = 1'b1;
        phase_n   = '0;
        ch_n      = CH_RED;
        clr_c     = 1'b1;
        state_n   = cont ? SETTLE : IDLE;
      end
      default: begin
        state_n = IDLE;
        ch_n    = CH_RED;
        phase_n = '0;
      end
    endcase
  end

  // Largest held count wins; ties favour red, then green
  always_comb begin
    max_c    = hold_r;
    winner_c = RED;
    if ((hold_r >= hold_g) && (hold_r >= hold_b)) begin
      max_c    = hold_r;
      winner_c = RED;
    end else if (hold_g >= hold_b) begin
      max_c    = hold_g;
      winner_c = GREEN;
    end else begin
      max_c    = hold_b;
      winner_c = BLUE;
    end
    color_c = (max_c < MIN_C) ? NONE : winner_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r    <= '0;
      hold_g    <= '0;
      hold_b    <= '0;
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
      color     <= NONE;
      done      <= 1'b0;
      busy      <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
    end else begin
      if (store_c) begin
        case (ch)
          CH_GREEN: hold_g <= count_c;
          CH_BLUE:  hold_b <= count_c;
          default:  hold_r <= count_c;
        endcase
      end
      if (publish_c) begin
        red_cnt   <= hold_r;
        green_cnt <= hold_g;
        blue_cnt  <= hold_b;
        color     <= color_c;
      end
      done     <= publish_c;
      busy     <= (state_n != IDLE);
      {s2, s3} <= filter_code(ch_n);
    end
  end

endmodule
